// File: rtl/shift_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_operand_stage
// Description : ID/EX pipeline register for shift instructions. Decodes the
//               shift opcode, resolves rs/rt through EX/MEM and MEM/WB
//               forwarding at capture time, and drives registered amount,
//               value and mode straight into the EX-stage barrel shifter.
//               While stalled, held operands keep tracking the retiring
//               producers so they never go stale.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [2:0]         id_op,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [DATA_W-1:0]  id_rs_val,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [DATA_W-1:0]  id_rt_val,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               exm_wen,
    input  logic [RADDR_W-1:0] exm_waddr,
    input  logic [DATA_W-1:0]  exm_wdata,
    input  logic               mwb_wen,
    input  logic [RADDR_W-1:0] mwb_waddr,
    input  logic [DATA_W-1:0]  mwb_wdata,
    input  logic               stall,
    input  logic               flush,
    output logic [SHAMT_W-1:0] sh_a,
    output logic [DATA_W-1:0]  sh_b,
    output logic [1:0]         sh_aluc,
    output logic               sh_zero_amt,
    output logic               ex_valid,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               illegal_op
);

    // Opcode encodings from the decoder
    localparam logic [2:0] c_OP_SLL  = 3'b000;
    localparam logic [2:0] c_OP_SRL  = 3'b001;
    localparam logic [2:0] c_OP_SRA  = 3'b010;
    localparam logic [2:0] c_OP_SLLV = 3'b100;
    localparam logic [2:0] c_OP_SRLV = 3'b101;
    localparam logic [2:0] c_OP_SRAV = 3'b110;

    // Barrel shifter mode encodings
    localparam logic [1:0] c_ALUC_SRA = 2'b00;
    localparam logic [1:0] c_ALUC_SRL = 2'b01;
    localparam logic [1:0] c_ALUC_SLL = 2'b10;

    localparam logic [RADDR_W-1:0] c_ADDR_ZERO = '0;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic               r_valid;
    logic [SHAMT_W-1:0] r_sh_a;
    logic [DATA_W-1:0]  r_sh_b;
    logic [1:0]         r_aluc;
    logic               r_zero_amt;
    logic [RADDR_W-1:0] r_rd_addr;
    logic               r_illegal;
    logic [RADDR_W-1:0] r_rs_addr;
    logic [RADDR_W-1:0] r_rt_addr;
    logic               r_var;

    // Decode
    logic               w_legal;
    logic               w_var;
    logic [1:0]         w_aluc;

    // Capture-time forwarding
    logic               w_rs_exm_hit;
    logic               w_rs_mwb_hit;
    logic               w_rt_exm_hit;
    logic               w_rt_mwb_hit;
    logic [DATA_W-1:0]  w_rs_fwd;
    logic [DATA_W-1:0]  w_rt_fwd;
    logic [SHAMT_W-1:0] w_ld_sh_a;

    // Stall-time refresh of held operands
    logic               w_hrs_exm_hit;
    logic               w_hrs_mwb_hit;
    logic               w_hrt_exm_hit;
    logic               w_hrt_mwb_hit;
    logic [SHAMT_W-1:0] w_ref_sh_a;
    logic [DATA_W-1:0]  w_ref_sh_b;

    // Next state
    logic               w_nxt_valid;
    logic [SHAMT_W-1:0] w_nxt_sh_a;
    logic [DATA_W-1:0]  w_nxt_sh_b;
    logic [1:0]         w_nxt_aluc;
    logic               w_nxt_zero_amt;
    logic [RADDR_W-1:0] w_nxt_rd_addr;
    logic               w_nxt_illegal;
    logic [RADDR_W-1:0] w_nxt_rs_addr;
    logic [RADDR_W-1:0] w_nxt_rt_addr;
    logic               w_nxt_var;

    // Decode the opcode into legality, variable-amount flag and shifter mode
    always_comb begin
        w_legal = 1'b0;
        w_var   = 1'b0;
        w_aluc  = c_ALUC_SLL;
        case (id_op)
            c_OP_SLL:  begin w_legal = 1'b1; w_var = 1'b0; w_aluc = c_ALUC_SLL; end
            c_OP_SRL:  begin w_legal = 1'b1; w_var = 1'b0; w_aluc = c_ALUC_SRL; end
            c_OP_SRA:  begin w_legal = 1'b1; w_var = 1'b0; w_aluc = c_ALUC_SRA; end
            c_OP_SLLV: begin w_legal = 1'b1; w_var = 1'b1; w_aluc = c_ALUC_SLL; end
            c_OP_SRLV: begin w_legal = 1'b1; w_var = 1'b1; w_aluc = c_ALUC_SRL; end
            c_OP_SRAV: begin w_legal = 1'b1; w_var = 1'b1; w_aluc = c_ALUC_SRA; end
            default:   begin w_legal = 1'b0; w_var = 1'b0; w_aluc = c_ALUC_SLL; end
        endcase
    end

    // Match ID source addresses against in-flight writers ($0 never forwards)
    always_comb begin
        w_rs_exm_hit = (id_rs_addr != c_ADDR_ZERO) && exm_wen && (exm_waddr == id_rs_addr);
        w_rs_mwb_hit = (id_rs_addr != c_ADDR_ZERO) && mwb_wen && (mwb_waddr == id_rs_addr);
        w_rt_exm_hit = (id_rt_addr != c_ADDR_ZERO) && exm_wen && (exm_waddr == id_rt_addr);
        w_rt_mwb_hit = (id_rt_addr != c_ADDR_ZERO) && mwb_wen && (mwb_waddr == id_rt_addr);
    end

    // Select forwarded source values; the younger EX/MEM result wins
    always_comb begin
        w_rs_fwd = id_rs_val;
        if (w_rs_exm_hit) begin
            w_rs_fwd = exm_wdata;
        end else if (w_rs_mwb_hit) begin
            w_rs_fwd = mwb_wdata;
        end

        w_rt_fwd = id_rt_val;
        if (w_rt_exm_hit) begin
            w_rt_fwd = exm_wdata;
        end else if (w_rt_mwb_hit) begin
            w_rt_fwd = mwb_wdata;
        end

        // Variable shifts take only the low rs bits as the amount
        w_ld_sh_a = w_var ? w_rs_fwd[SHAMT_W-1:0] : id_shamt;
    end

    // Match held source addresses against writers retiring during a stall
    always_comb begin
        w_hrs_exm_hit = r_valid && (r_rs_addr != c_ADDR_ZERO) && exm_wen && (exm_waddr == r_rs_addr);
        w_hrs_mwb_hit = r_valid && (r_rs_addr != c_ADDR_ZERO) && mwb_wen && (mwb_waddr == r_rs_addr);
        w_hrt_exm_hit = r_valid && (r_rt_addr != c_ADDR_ZERO) && exm_wen && (exm_waddr == r_rt_addr);
        w_hrt_mwb_hit = r_valid && (r_rt_addr != c_ADDR_ZERO) && mwb_wen && (mwb_waddr == r_rt_addr);
    end

    // Refreshed operand values; fixed shifts keep their immediate amount
    always_comb begin
        w_ref_sh_b = r_sh_b;
        if (w_hrt_exm_hit) begin
            w_ref_sh_b = exm_wdata;
        end else if (w_hrt_mwb_hit) begin
            w_ref_sh_b = mwb_wdata;
        end

        w_ref_sh_a = r_sh_a;
        if (r_var) begin
            if (w_hrs_exm_hit) begin
                w_ref_sh_a = exm_wdata[SHAMT_W-1:0];
            end else if (w_hrs_mwb_hit) begin
                w_ref_sh_a = mwb_wdata[SHAMT_W-1:0];
            end
        end
    end

    // Next-state selection: flush > stall > load (reset handled in the register)
    always_comb begin
        // Bubble by default
        w_nxt_valid    = 1'b0;
        w_nxt_sh_a     = '0;
        w_nxt_sh_b     = '0;
        w_nxt_aluc     = c_ALUC_SLL;
        w_nxt_zero_amt = 1'b1;
        w_nxt_rd_addr  = '0;
        w_nxt_illegal  = 1'b0;
        w_nxt_rs_addr  = '0;
        w_nxt_rt_addr  = '0;
        w_nxt_var      = 1'b0;

        if (flush) begin
            // keep the bubble defaults
            w_nxt_valid = 1'b0;
        end else if (stall) begin
            w_nxt_valid    = r_valid;
            w_nxt_sh_a     = w_ref_sh_a;
            w_nxt_sh_b     = w_ref_sh_b;
            w_nxt_aluc     = r_aluc;
            w_nxt_zero_amt = (w_ref_sh_a == '0);
            w_nxt_rd_addr  = r_rd_addr;
            w_nxt_illegal  = 1'b0;
            w_nxt_rs_addr  = r_rs_addr;
            w_nxt_rt_addr  = r_rt_addr;
            w_nxt_var      = r_var;
        end else if (id_valid && w_legal) begin
            w_nxt_valid    = 1'b1;
            w_nxt_sh_a     = w_ld_sh_a;
            w_nxt_sh_b     = w_rt_fwd;
            w_nxt_aluc     = w_aluc;
            w_nxt_zero_amt = (w_ld_sh_a == '0);
            w_nxt_rd_addr  = id_rd_addr;
            w_nxt_illegal  = 1'b0;
            w_nxt_rs_addr  = id_rs_addr;
            w_nxt_rt_addr  = id_rt_addr;
            w_nxt_var      = w_var;
        end else begin
            // Idle or illegal: bubble, flagging only a real illegal opcode
            w_nxt_illegal = id_valid && !w_legal;
        end
    end

    // Stage register with synchronous reset into the bubble state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_sh_a     <= '0;
            r_sh_b     <= '0;
            r_aluc     <= c_ALUC_SLL;
            r_zero_amt <= 1'b1;
            r_rd_addr  <= '0;
            r_illegal  <= 1'b0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_var      <= 1'b0;
        end else begin
            r_valid    <= w_nxt_valid;
            r_sh_a     <= w_nxt_sh_a;
            r_sh_b     <= w_nxt_sh_b;
            r_aluc     <= w_nxt_aluc;
            r_zero_amt <= w_nxt_zero_amt;
            r_rd_addr  <= w_nxt_rd_addr;
            r_illegal  <= w_nxt_illegal;
            r_rs_addr  <= w_nxt_rs_addr;
            r_rt_addr  <= w_nxt_rt_addr;
            r_var      <= w_nxt_var;
        end
    end

    assign sh_a        = r_sh_a;
    assign sh_b        = r_sh_b;
    assign sh_aluc     = r_aluc;
    assign sh_zero_amt = r_zero_amt;
    assign ex_valid    = r_valid;
    assign ex_rd_addr  = r_rd_addr;
    assign illegal_op  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_operand_stage
// Description : Directed self-checking bench for shift_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_operand_stage;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_valid;
    logic [2:0]         id_op;
    logic [SHAMT_W-1:0] id_shamt;
    logic [RADDR_W-1:0] id_rs_addr;
    logic [DATA_W-1:0]  id_rs_val;
    logic [RADDR_W-1:0] id_rt_addr;
    logic [DATA_W-1:0]  id_rt_val;
    logic [RADDR_W-1:0] id_rd_addr;
    logic               exm_wen;
    logic [RADDR_W-1:0] exm_waddr;
    logic [DATA_W-1:0]  exm_wdata;
    logic               mwb_wen;
    logic [RADDR_W-1:0] mwb_waddr;
    logic [DATA_W-1:0]  mwb_wdata;
    logic               stall;
    logic               flush;
    logic [SHAMT_W-1:0] sh_a;
    logic [DATA_W-1:0]  sh_b;
    logic [1:0]         sh_aluc;
    logic               sh_zero_amt;
    logic               ex_valid;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    shift_operand_stage #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W),
        .RADDR_W(RADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_op      (id_op),
        .id_shamt   (id_shamt),
        .id_rs_addr (id_rs_addr),
        .id_rs_val  (id_rs_val),
        .id_rt_addr (id_rt_addr),
        .id_rt_val  (id_rt_val),
        .id_rd_addr (id_rd_addr),
        .exm_wen    (exm_wen),
        .exm_waddr  (exm_waddr),
        .exm_wdata  (exm_wdata),
        .mwb_wen    (mwb_wen),
        .mwb_waddr  (mwb_waddr),
        .mwb_wdata  (mwb_wdata),
        .stall      (stall),
        .flush      (flush),
        .sh_a       (sh_a),
        .sh_b       (sh_b),
        .sh_aluc    (sh_aluc),
        .sh_zero_amt(sh_zero_amt),
        .ex_valid   (ex_valid),
        .ex_rd_addr (ex_rd_addr),
        .illegal_op (illegal_op)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        exm_wen = 1'b0; exm_waddr = '0; exm_wdata = '0;
        mwb_wen = 1'b0; mwb_waddr = '0; mwb_wdata = '0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] shamt,
                         input logic [4:0] rs, input logic [31:0] rsv,
                         input logic [4:0] rt, input logic [31:0] rtv,
                         input logic [4:0] rd);
        id_valid = 1'b1; id_op = op; id_shamt = shamt;
        id_rs_addr = rs; id_rs_val = rsv;
        id_rt_addr = rt; id_rt_val = rtv;
        id_rd_addr = rd;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_op = 3'b000; id_shamt = '0;
        id_rs_addr = '0; id_rs_val = '0; id_rt_addr = '0; id_rt_val = '0; id_rd_addr = '0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, ex_valid, 1'b0);
        check({tag, ".sh_a"}, sh_a, 5'd0);
        check({tag, ".sh_b"}, sh_b, 32'h0);
        check({tag, ".aluc"}, sh_aluc, 2'b10);
        check({tag, ".zero"}, sh_zero_amt, 1'b1);
        check({tag, ".rd"}, ex_rd_addr, 5'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        idle();
        clear_fwd();

        // Reset then idle
        step(); step();
        check_bubble("rst");
        check("rst.illegal", illegal_op, 1'b0);
        rst = 1'b0;
        step();
        check_bubble("idle");

        // Fixed SRA by 4
        issue(3'b010, 5'd4, 5'd0, 32'h0, 5'd3, 32'hF000_0000, 5'd9);
        step();
        check("sra.sh_a", sh_a, 5'd4);
        check("sra.sh_b", sh_b, 32'hF000_0000);
        check("sra.aluc", sh_aluc, 2'b00);
        check("sra.valid", ex_valid, 1'b1);
        check("sra.zero", sh_zero_amt, 1'b0);
        check("sra.rd", ex_rd_addr, 5'd9);

        // SLLV: rs from EX/MEM, rt from MEM/WB
        issue(3'b100, 5'd17, 5'd5, 32'h0000_0055, 5'd6, 32'h0, 5'd10);
        exm_wen = 1'b1; exm_waddr = 5'd5; exm_wdata = 32'h0000_0023;
        mwb_wen = 1'b1; mwb_waddr = 5'd6; mwb_wdata = 32'h1234_5678;
        step();
        check("sllv.sh_a", sh_a, 5'd3);
        check("sllv.sh_b", sh_b, 32'h1234_5678);
        check("sllv.aluc", sh_aluc, 2'b10);

        // Both writers hit rs: EX/MEM must win over MEM/WB ($5=9)
        issue(3'b100, 5'd0, 5'd5, 32'h0000_0055, 5'd6, 32'h1234_5678, 5'd10);
        exm_wen = 1'b1; exm_waddr = 5'd5; exm_wdata = 32'h0000_0023;
        mwb_wen = 1'b1; mwb_waddr = 5'd5; mwb_wdata = 32'h0000_0009;
        step();
        check("prio.sh_a", sh_a, 5'd3);
        check("prio.sh_b", sh_b, 32'h1234_5678);

        // MEM/WB alone on rs
        issue(3'b110, 5'd0, 5'd5, 32'h0000_0055, 5'd6, 32'h8000_0000, 5'd11);
        exm_wen = 1'b0;
        step();
        check("mwb.sh_a", sh_a, 5'd9);
        check("mwb.aluc", sh_aluc, 2'b00);

        // rs == rt both forward from the same EX/MEM result
        clear_fwd();
        issue(3'b100, 5'd0, 5'd1, 32'h0, 5'd1, 32'h0, 5'd1);
        exm_wen = 1'b1; exm_waddr = 5'd1; exm_wdata = 32'h0000_0021;
        step();
        check("same.sh_a", sh_a, 5'd1);
        check("same.sh_b", sh_b, 32'h0000_0021);

        // Register 0 is never forwarded
        clear_fwd();
        issue(3'b000, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2);
        exm_wen = 1'b1; exm_waddr = 5'd0; exm_wdata = 32'hFFFF_FFFF;
        step();
        check("r0.sh_b", sh_b, 32'h0);
        check("r0.valid", ex_valid, 1'b1);
        check("r0.zero", sh_zero_amt, 1'b1);

        // SRLV with stale rs=1, then stall while MEM/WB retires $7=0
        clear_fwd();
        issue(3'b101, 5'd12, 5'd7, 32'h0000_0001, 5'd8, 32'h0000_0080, 5'd4);
        step();
        check("srlv.sh_a", sh_a, 5'd1);
        check("srlv.aluc", sh_aluc, 2'b01);
        stall = 1'b1;
        issue(3'b000, 5'd2, 5'd0, 32'h0, 5'd3, 32'h1, 5'd13);
        mwb_wen = 1'b1; mwb_waddr = 5'd7; mwb_wdata = 32'h0;
        step();
        check("ref.sh_a", sh_a, 5'd0);
        check("ref.zero", sh_zero_amt, 1'b1);
        check("ref.aluc", sh_aluc, 2'b01);
        check("ref.sh_b", sh_b, 32'h0000_0080);
        check("ref.rd", ex_rd_addr, 5'd4);
        // Still stalled: EX/MEM now retires $8, rt refreshes
        clear_fwd();
        exm_wen = 1'b1; exm_waddr = 5'd8; exm_wdata = 32'hCAFE_0001;
        step();
        check("ref2.sh_b", sh_b, 32'hCAFE_0001);
        check("ref2.valid", ex_valid, 1'b1);
        // Release stall: the SLL waiting in ID loads
        stall = 1'b0;
        clear_fwd();
        step();
        check("rel.sh_a", sh_a, 5'd2);
        check("rel.aluc", sh_aluc, 2'b10);
        check("rel.sh_b", sh_b, 32'h1);
        check("rel.rd", ex_rd_addr, 5'd13);

        // Fixed SRL: stall with a write to rs must not disturb sh_a
        issue(3'b001, 5'd6, 5'd7, 32'h0000_0003, 5'd8, 32'h5, 5'd14);
        step();
        stall = 1'b1;
        exm_wen = 1'b1; exm_waddr = 5'd7; exm_wdata = 32'h0;
        step();
        check("fix.sh_a", sh_a, 5'd6);
        check("fix.zero", sh_zero_amt, 1'b0);

        // Flush wins over stall
        clear_fwd();
        flush = 1'b1;
        step();
        check_bubble("flush");
        flush = 1'b0;
        stall = 1'b0;

        // Illegal opcode: bubble plus a one-cycle pulse
        issue(3'b011, 5'd5, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
        step();
        check("ill.valid", ex_valid, 1'b0);
        check("ill.pulse", illegal_op, 1'b1);
        check("ill.rd", ex_rd_addr, 5'd0);
        idle();
        step();
        check("ill.end", illegal_op, 1'b0);

        // Illegal pulse drops during a stall
        issue(3'b111, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0);
        step();
        check("ill2.pulse", illegal_op, 1'b1);
        stall = 1'b1;
        step();
        check("ill2.stall", illegal_op, 1'b0);
        check("ill2.valid", ex_valid, 1'b0);
        stall = 1'b0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- ID/EX pipeline stage for shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV).
- Captures decoded shift operands from ID and applies EX/MEM and MEM/WB forwarding at capture time.
- Honours stall and flush from the hazard unit.
- Presents registered amount, value and mode directly to the EX-stage barrel shifter. Shifter encoding: aluc 00 = arithmetic right, 01 = logical right, 1x = left.

Parameters:
DATA_W, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 DATA_W)
RADDR_W, 5, register-file address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a shift instruction this cycle
id_op  in  3  000 SLL, 001 SRL, 010 SRA, 100 SLLV, 101 SRLV, 110 SRAV; others illegal
id_shamt  in  SHAMT_W  instruction shamt field
id_rs_addr  in  RADDR_W  rs index
id_rs_val  in  DATA_W  regfile rs read data
id_rt_addr  in  RADDR_W  rt index
id_rt_val  in  DATA_W  regfile rt read data
id_rd_addr  in  RADDR_W  destination index
exm_wen  in  1  EX/MEM writes a register
exm_waddr  in  RADDR_W  EX/MEM destination
exm_wdata  in  DATA_W  EX/MEM result
mwb_wen  in  1  MEM/WB writes a register
mwb_waddr  in  RADDR_W  MEM/WB destination
mwb_wdata  in  DATA_W  MEM/WB result
stall  in  1  hold stage contents
flush  in  1  replace contents with bubble
sh_a  out  SHAMT_W  shift amount to shifter
sh_b  out  DATA_W  value to shift
sh_aluc  out  2  shifter mode
sh_zero_amt  out  1  sh_a == 0; consumer must ignore shifter carry
ex_valid  out  1  stage holds a real instruction
ex_rd_addr  out  RADDR_W  destination carried to EX
illegal_op  out  1  one-cycle pulse, illegal id_op captured

Behaviour:
- Update priority each rising edge: rst > flush > stall > load.
- Bubble state: ex_valid=0, sh_a=0, sh_b=0, sh_aluc=2'b10, sh_zero_amt=1, ex_rd_addr=0, illegal_op=0, internal held rs/rt addresses=0, variable flag=0.
- rst: enter bubble state.
- flush, including flush with stall: enter bubble state. Flush wins over stall.
- Load (no stall, no flush): latency 1 cycle, ID to outputs.
  - ex_valid <= id_valid & legal op.
  - Operand forwarding, per source: if addr != 0 and exm_wen & exm_waddr == addr, use exm_wdata. Else if addr != 0 and mwb_wen & mwb_waddr == addr, use mwb_wdata. Else use regfile value. EX/MEM has priority over MEM/WB. Address 0 is never forwarded.
  - sh_b <= forwarded rt.
  - sh_a <= id_shamt for fixed ops; forwarded rs[SHAMT_W-1:0] for variable ops. Upper rs bits are discarded.
  - sh_aluc: SLL/SLLV -> 10, SRL/SRLV -> 01, SRA/SRAV -> 00.
  - sh_zero_amt <= next sh_a == 0.
  - ex_rd_addr <= id_rd_addr.
  - Latch rs/rt addresses and the variable flag internally.
- Illegal op with id_valid=1: load bubble state and assert illegal_op for exactly one cycle.
- id_valid=0: load bubble state, no illegal pulse.
- Stall with no flush: all outputs hold, with refresh.
  - Refresh keeps held operands from going stale while the producer retires. Each cycle, if ex_valid and a held source address is nonzero and matches a write, apply the same forwarding rule and priority.
  - sh_b refreshes on an rt match.
  - sh_a and sh_zero_amt refresh on an rs match only when the variable flag is set.
  - illegal_op deasserts during stall.
- Load-use hazards are resolved upstream by stall. This stage performs no hazard detection.
- rs == rt (e.g. SLLV $1,$1,$1): both sources forward independently from the same data.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ex_valid=0, sh_aluc=10, sh_zero_amt=1, all data 0; these hold with id_valid=0 after rst drops.
- Fixed SRA: id_op=010, shamt=4, rt=$3=32'hF000_0000 -> next cycle sh_a=4, sh_b=32'hF000_0000, sh_aluc=00, ex_valid=1, sh_zero_amt=0.
- Variable SLLV with double forwarding: rs=$5, rt=$6. exm writes $5=32'h0000_0023; mwb writes $6=32'h1234_5678 and also $5=9 -> sh_a=3 (EX/MEM priority, low 5 bits), sh_b=32'h1234_5678, sh_aluc=10.
- Register 0: rt=$0 with exm_wen=1, exm_waddr=0, exm_wdata=32'hFFFF_FFFF -> sh_b equals id_rt_val (0), not forwarded.
- Stall refresh: SRLV captured with rs=$7 stale value 1. Next cycle stall=1 and mwb writes $7=0 -> sh_a=0, sh_zero_amt=1, sh_aluc stays 01. Then stall=0 -> new instruction loads.
- Flush over stall, and illegal op: stall=1 with flush=1 -> bubble next cycle. id_op=011 with id_valid=1 -> ex_valid=0, illegal_op high exactly one cycle.
